// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch slice: opcodes, instruction field
// positions, dispatcher FSM states and opcode classes.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_OR   = 5'h02;
  localparam logic [4:0] OP_AND  = 5'h03;
  localparam logic [4:0] OP_SG   = 5'h04;
  localparam logic [4:0] OP_SL   = 5'h05;
  localparam logic [4:0] OP_SE   = 5'h06;
  localparam logic [4:0] OP_MULT = 5'h07;
  localparam logic [4:0] OP_DIV  = 5'h08;
  localparam logic [4:0] OP_MOD  = 5'h09;
  localparam logic [4:0] OP_NOT  = 5'h10;
  localparam logic [4:0] OP_JL   = 5'h12;
  localparam logic [4:0] OP_SW   = 5'h19;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 27;
  localparam int unsigned RD_MSB  = 26;
  localparam int unsigned RD_LSB  = 22;
  localparam int unsigned RS1_MSB = 21;
  localparam int unsigned RS1_LSB = 17;
  localparam int unsigned RS2_MSB = 16;
  localparam int unsigned RS2_LSB = 12;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_RETIRE
  } state_t;

  typedef enum logic [1:0] {
    CLS_REG,
    CLS_STORE,
    CLS_JUMP,
    CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational opcode decode: retire class and divide/modulo flag.
module alu_instr_decode
  import alu_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_t  op_class,
  output logic       is_divmod
);

  always_comb begin
    op_class  = CLS_ILLEGAL;
    is_divmod = 1'b0;
    case (opcode)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SG, OP_SL, OP_SE,
      OP_MULT, OP_DIV, OP_MOD, OP_NOT: op_class = CLS_REG;
      OP_SW:                           op_class = CLS_STORE;
      OP_JL:                           op_class = CLS_JUMP;
      default:                         op_class = CLS_ILLEGAL;
    endcase
    is_divmod = (opcode == OP_DIV) || (opcode == OP_MOD);
  end

endmodule

// File: rtl/alu_dispatch.sv
// Four-cycle issue controller: accept, read register file, capture operands,
// then drive the ALU and retire the result as a write, store, jump or error.
module alu_dispatch
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [RADDR_W-1:0] rf_rd_addr1,
  output logic [RADDR_W-1:0] rf_rd_addr2,
  input  logic [DATA_W-1:0]  rf_rd_data1,
  input  logic [DATA_W-1:0]  rf_rd_data2,
  output logic [4:0]         alu_op_code,
  output logic [DATA_W-1:0]  alu_data1,
  output logic [DATA_W-1:0]  alu_data2,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               rf_wr_en,
  output logic [RADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0]  rf_wr_data,
  output logic               mem_wr_en,
  output logic [DATA_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wr_data,
  output logic               jump_valid,
  output logic [DATA_W-1:0]  jump_target,
  output logic               done,
  output logic               err_illegal,
  output logic               err_div_zero
);

  state_t              state_q, state_d;
  logic [4:0]          opcode_q, rd_q, rs1_q, rs2_q;
  logic [DATA_W-1:0]   opnd1_q, opnd2_q;
  op_class_t           op_class;
  logic                is_divmod;
  logic                unused_low_bits;

  assign unused_low_bits = ^instr[RS2_LSB-1:0];

  alu_instr_decode u_decode (
    .opcode    (opcode_q),
    .op_class  (op_class),
    .is_divmod (is_divmod)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opnd1_q  <= '0;
      opnd2_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && instr_valid) begin
        opcode_q <= instr[OPC_MSB:OPC_LSB];
        rd_q     <= instr[RD_MSB:RD_LSB];
        rs1_q    <= instr[RS1_MSB:RS1_LSB];
        rs2_q    <= instr[RS2_MSB:RS2_LSB];
      end
      if (state_q == ST_EXEC) begin
        opnd1_q <= rf_rd_data1;
        opnd2_q <= rf_rd_data2;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    rf_rd_addr1  = '0;
    rf_rd_addr2  = '0;
    alu_op_code  = '0;
    alu_data1    = '0;
    alu_data2    = '0;
    rf_wr_en     = 1'b0;
    rf_wr_addr   = '0;
    rf_wr_data   = '0;
    mem_wr_en    = 1'b0;
    mem_addr     = '0;
    mem_wr_data  = '0;
    jump_valid   = 1'b0;
    jump_target  = '0;
    done         = 1'b0;
    err_illegal  = 1'b0;
    err_div_zero = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_READ;
      end
      ST_READ: begin
        rf_rd_addr1 = RADDR_W'(rs1_q);
        rf_rd_addr2 = RADDR_W'(rs2_q);
        state_d     = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RETIRE;
      ST_RETIRE: begin
        state_d     = ST_IDLE;
        alu_op_code = opcode_q;
        alu_data1   = opnd1_q;
        alu_data2   = opnd2_q;
        // A retire cycle coinciding with reset is discarded, so every strobe is gated.
        if (!rst) begin
          done = 1'b1;
          case (op_class)
            CLS_REG: begin
              if (is_divmod && opnd2_q == '0) begin
                err_div_zero = 1'b1;
              end else if (rd_q != '0) begin
                rf_wr_en   = 1'b1;
                rf_wr_addr = RADDR_W'(rd_q);
                rf_wr_data = alu_result;
              end
            end
            CLS_STORE: begin
              mem_wr_en   = 1'b1;
              mem_addr    = opnd1_q;
              mem_wr_data = alu_result;
            end
            CLS_JUMP: begin
              jump_valid  = 1'b1;
              jump_target = opnd1_q;
            end
            default: err_illegal = 1'b1;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch with a behavioural register file and ALU; retire
// results are checked against a queue of expected outcomes.
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_rd_addr1, rf_rd_addr2;
  logic [31:0] rf_rd_data1, rf_rd_data2;
  logic [4:0]  alu_op_code;
  logic [31:0] alu_data1, alu_data2, alu_result;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data;
  logic        jump_valid;
  logic [31:0] jump_target;
  logic        done, err_illegal, err_div_zero;

  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;
  logic [31:0] regs [32];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  typedef struct {
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic        mem_we;
    logic [31:0] ma;
    logic [31:0] md;
    logic        jv;
    logic [31:0] jt;
    logic        ei;
    logic        ez;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  always #5 clk = ~clk;

  alu_dispatch #(.DATA_W(32), .RADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_rd_addr1(rf_rd_addr1), .rf_rd_addr2(rf_rd_addr2),
    .rf_rd_data1(rf_rd_data1), .rf_rd_data2(rf_rd_data2),
    .alu_op_code(alu_op_code), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_result(alu_result),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .done(done), .err_illegal(err_illegal), .err_div_zero(err_div_zero)
  );

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'h00: return a + b;
      5'h01: return a - b;
      5'h02: return a | b;
      5'h03: return a & b;
      5'h04: return (a > b) ? 32'd1 : 32'd0;
      5'h05: return (a < b) ? 32'd1 : 32'd0;
      5'h06: return (a == b) ? 32'd1 : 32'd0;
      5'h07: return a * b;
      5'h08: return (b == 0) ? 32'd0 : a / b;
      5'h09: return (b == 0) ? 32'd0 : a % b;
      5'h10: return ~a;
      5'h19: return b;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_op_code, alu_data1, alu_data2);

  // Synchronous register file: one-cycle read latency, r0 never written.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      rf_rd_data1 <= '0;
      rf_rd_data2 <= '0;
    end else begin
      rf_rd_data1 <= regs[rf_rd_addr1];
      rf_rd_data2 <= regs[rf_rd_addr2];
      if (pl_en) regs[pl_addr] <= pl_data;
      else if (rf_wr_en && rf_wr_addr != 5'd0) regs[rf_wr_addr] <= rf_wr_data;
    end
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 12'hABC};
  endfunction

  function automatic exp_t mk(input logic rf_we, input logic [4:0] rf_wa, input logic [31:0] rf_wd,
                              input logic mem_we, input logic [31:0] ma, input logic [31:0] md,
                              input logic jv, input logic [31:0] jt, input logic ei, input logic ez);
    exp_t e;
    e.rf_we = rf_we; e.rf_wa = rf_wa; e.rf_wd = rf_wd;
    e.mem_we = mem_we; e.ma = ma; e.md = md;
    e.jv = jv; e.jt = jt; e.ei = ei; e.ez = ez;
    return e;
  endfunction

  // Retire monitor: every done pulse pops one expectation; strobes without done are errors.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1, required no retire at %0t", $time);
      end else begin
        e_mon = sb.pop_front();
        if ({rf_wr_en, rf_wr_addr, rf_wr_data, mem_wr_en, mem_addr, mem_wr_data,
             jump_valid, jump_target, err_illegal, err_div_zero} !==
            {e_mon.rf_we, e_mon.rf_wa, e_mon.rf_wd, e_mon.mem_we, e_mon.ma, e_mon.md,
             e_mon.jv, e_mon.jt, e_mon.ei, e_mon.ez}) begin
          errors++;
          $display("FAIL retire: got rf=%b/%0d/%h mem=%b/%h/%h jmp=%b/%h ill=%b dz=%b, required rf=%b/%0d/%h mem=%b/%h/%h jmp=%b/%h ill=%b dz=%b",
                   rf_wr_en, rf_wr_addr, rf_wr_data, mem_wr_en, mem_addr, mem_wr_data,
                   jump_valid, jump_target, err_illegal, err_div_zero,
                   e_mon.rf_we, e_mon.rf_wa, e_mon.rf_wd, e_mon.mem_we, e_mon.ma, e_mon.md,
                   e_mon.jv, e_mon.jt, e_mon.ei, e_mon.ez);
        end
      end
    end else if (rf_wr_en | mem_wr_en | jump_valid | err_illegal | err_div_zero) begin
      checks++;
      errors++;
      $display("FAIL stray_strobe: got rf=%b mem=%b jmp=%b ill=%b dz=%b without done, required all 0",
               rf_wr_en, mem_wr_en, jump_valid, err_illegal, err_div_zero);
    end
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    @(negedge clk);
    instr_valid = 1'b1;
    instr = w;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: got instr_ready=0 after 50 cycles, required 1");
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = '0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && instr_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(sb.size() == 0 && instr_ready)) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending retires, required 0", sb.size());
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", instr_ready);
    end
    checks++;
    if ({rf_rd_addr1, rf_rd_addr2, alu_op_code, alu_data1, alu_data2, rf_wr_en, rf_wr_addr,
         rf_wr_data, mem_wr_en, mem_addr, mem_wr_data, jump_valid, jump_target, done,
         err_illegal, err_div_zero} !== '0) begin
      errors++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
    end
  endtask

  task automatic test_add();
    sb.push_back(mk(1, 5'd3, 32'd12, 0, 0, 0, 0, 0, 0, 0));
    send(enc(5'h00, 5'd3, 5'd1, 5'd2));
    @(negedge clk);
    checks++;
    if ({instr_ready, rf_rd_addr1, rf_rd_addr2} !== {1'b0, 5'd1, 5'd2}) begin
      errors++; $display("FAIL add_read: got ready=%b a1=%0d a2=%0d, required 0/1/2",
                         instr_ready, rf_rd_addr1, rf_rd_addr2);
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, done} !== 2'b00) begin
      errors++; $display("FAIL add_exec: got ready=%b done=%b, required 0/0", instr_ready, done);
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, done, alu_op_code, alu_data1, alu_data2} !== {1'b0, 1'b1, 5'h00, 32'd5, 32'd7}) begin
      errors++; $display("FAIL add_retire: got ready=%b done=%b op=%h d1=%0d d2=%0d, required 0/1/00/5/7",
                         instr_ready, done, alu_op_code, alu_data1, alu_data2);
    end
    @(negedge clk);
    checks++;
    if ({instr_ready, done} !== 2'b10) begin
      errors++; $display("FAIL add_reready: got ready=%b done=%b, required 1/0", instr_ready, done);
    end
    // Reads r3 immediately after it was written: 12 * 7.
    sb.push_back(mk(1, 5'd16, 32'd84, 0, 0, 0, 0, 0, 0, 0));
    send(enc(5'h07, 5'd16, 5'd3, 5'd2));
    drain();
  endtask

  task automatic test_divmod();
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    send(enc(5'h08, 5'd4, 5'd6, 5'd7));
    sb.push_back(mk(1, 5'd4, 32'd6, 0, 0, 0, 0, 0, 0, 0));
    send(enc(5'h08, 5'd4, 5'd6, 5'd8));
    sb.push_back(mk(1, 5'd12, 32'd2, 0, 0, 0, 0, 0, 0, 0));
    send(enc(5'h09, 5'd12, 5'd6, 5'd8));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    send(enc(5'h09, 5'd12, 5'd6, 5'd0));
    drain();
  endtask

  task automatic test_store_jump_illegal();
    sb.push_back(mk(0, 0, 0, 1, 32'h100, 32'hDEAD, 0, 0, 0, 0));
    send(enc(5'h19, 5'd5, 5'd9, 5'd10));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h40, 0, 0));
    send(enc(5'h12, 5'd5, 5'd11, 5'd1));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    send(enc(5'h1F, 5'd5, 5'd1, 5'd2));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    send(enc(5'h11, 5'd5, 5'd1, 5'd2));
    sb.push_back(mk(1, 5'd17, 32'hFFFF_FFFA, 0, 0, 0, 0, 0, 0, 0));
    send(enc(5'h10, 5'd17, 5'd1, 5'd2));
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [3];
    int idx = 0;
    int d0 = done_cnt;
    prog[0] = enc(5'h02, 5'd13, 5'd1, 5'd2);
    prog[1] = enc(5'h01, 5'd0, 5'd1, 5'd2);
    prog[2] = enc(5'h03, 5'd14, 5'd1, 5'd2);
    sb.push_back(mk(1, 5'd13, 32'd7, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sb.push_back(mk(1, 5'd14, 32'd5, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    instr_valid = 1'b1;
    instr = prog[0];
    for (int c = 0; c < 12; c++) begin
      logic was_ready;
      was_ready = instr_ready;
      checks++;
      if (instr_ready !== ((c % 4) == 0)) begin
        errors++; $display("FAIL b2b_ready[%0d]: got %b, required %b", c, instr_ready, (c % 4) == 0);
      end
      @(posedge clk); #1;
      if (was_ready && instr_valid) begin
        idx++;
        if (idx < 3) instr = prog[idx];
        else begin instr_valid = 1'b0; instr = '0; end
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    drain();
    checks++;
    if (done_cnt - d0 !== 3) begin
      errors++; $display("FAIL b2b_done_count: got %0d, required 3", done_cnt - d0);
    end
  endtask

  task automatic test_reset_midflight();
    int d0 = done_cnt;
    send(enc(5'h00, 5'd5, 5'd1, 5'd2));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1 ||
        {rf_rd_addr1, rf_rd_addr2, alu_op_code, alu_data1, alu_data2, rf_wr_en, rf_wr_addr,
         rf_wr_data, mem_wr_en, mem_addr, mem_wr_data, jump_valid, jump_target, done,
         err_illegal, err_div_zero} !== '0) begin
      errors++; $display("FAIL rst_exec_idle: got ready=%b done=%b wr=%b, required ready=1 and all outputs 0",
                         instr_ready, done, rf_wr_en);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt !== d0) begin
      errors++; $display("FAIL rst_exec_done: got %0d done pulses, required 0", done_cnt - d0);
    end
    // Second case: reset lands on the RETIRE cycle itself.
    send(enc(5'h00, 5'd5, 5'd1, 5'd2));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({done, rf_wr_en} !== 2'b00) begin
      errors++; $display("FAIL rst_retire_strobes: got done=%b wr=%b, required 0/0", done, rf_wr_en);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++; $display("FAIL rst_retire_ready: got %b, required 1", instr_ready);
    end
  endtask

  initial begin
    test_reset();
    preload(5'd1, 32'd5);
    preload(5'd2, 32'd7);
    preload(5'd6, 32'd20);
    preload(5'd7, 32'd0);
    preload(5'd8, 32'd3);
    preload(5'd9, 32'h100);
    preload(5'd10, 32'hDEAD);
    preload(5'd11, 32'h40);
    test_add();
    test_divmod();
    test_store_jump_illegal();
    test_back_to_back();
    test_reset_midflight();
    drain();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
